// File: rtl/fp80_pkg.sv
// Shared definitions for 80-bit extended-precision handling: field positions,
// exponent constants, the normaliser state encoding and operand classes.
package fp80_pkg;

    localparam int F80_EXP_MSB = 78;
    localparam int F80_EXP_LSB = 64;
    localparam int F80_MAN_MSB = 63;

    localparam logic [14:0] F80_EXP_MAX = 15'h7FFF;
    localparam logic [14:0] F80_BIAS    = 15'h3FFF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } norm_state_t;

    // Operand classes, listed in the priority order used by f80_classify.
    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_INFNAN,
        CLS_PSEUDO,
        CLS_DENORM,
        CLS_NORMAL,
        CLS_UNNORMAL
    } f80_class_t;

endpackage

// File: rtl/f80_classify.sv
// Combinational classifier for an 80-bit extended operand. The sign bit does
// not affect the class, so only exponent and mantissa are taken.
module f80_classify
    import fp80_pkg::*;
(
    input  logic [14:0] exp,
    input  logic [63:0] man,
    output f80_class_t  cls
);

    // Priority decode: a zero mantissa wins unless the exponent marks inf/NaN.
    always_comb begin
        cls = CLS_UNNORMAL;
        if (man == 64'd0 && exp != F80_EXP_MAX) begin
            cls = CLS_ZERO;
        end else if (exp == F80_EXP_MAX) begin
            cls = CLS_INFNAN;
        end else if (exp == 15'd0 && man[F80_MAN_MSB]) begin
            cls = CLS_PSEUDO;
        end else if (exp == 15'd0) begin
            cls = CLS_DENORM;
        end else if (man[F80_MAN_MSB]) begin
            cls = CLS_NORMAL;
        end else begin
            cls = CLS_UNNORMAL;
        end
    end

endmodule

// File: rtl/f80_normalize_seq.sv
// Iterative pre-normaliser for 80-bit extended operands. Unnormals are shifted
// left a STEP-bit group or a single bit per cycle until the explicit integer
// bit is set or the exponent bottoms out, at which point the result becomes a
// true denormal. One operand is processed at a time behind valid/ready.
module f80_normalize_seq
    import fp80_pkg::*;
#(
    parameter int STEP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [79:0] i_a,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [79:0] o_a,
    output logic        o_zero,
    output logic        o_denorm,
    output logic [5:0]  o_shift
);

    norm_state_t state_reg;
    logic        sign_reg;
    logic [14:0] exp_reg;
    logic [63:0] man_reg;
    logic [5:0]  shift_reg;
    logic        zero_reg;
    logic        denorm_reg;
    logic        i_ready_reg;
    logic        o_valid_reg;

    f80_class_t  in_cls;

    f80_classify u_classify (
        .exp (i_a[F80_EXP_MSB:F80_EXP_LSB]),
        .man (i_a[F80_MAN_MSB:0]),
        .cls (in_cls)
    );

    // Per-cycle shift candidate: a whole group when the top STEP bits are zero
    // and the exponent can absorb it without reaching 0, else a single bit.
    logic        step_ok;
    logic [63:0] man_next;
    logic [14:0] exp_next;
    logic [5:0]  shift_inc;

    always_comb begin
        step_ok   = (man_reg[63 -: STEP] == '0) && (exp_reg > 15'(STEP));
        man_next  = step_ok ? (man_reg << STEP) : (man_reg << 1);
        exp_next  = step_ok ? (exp_reg - 15'(STEP)) : (exp_reg - 15'd1);
        shift_inc = step_ok ? 6'(STEP) : 6'd1;
    end

    // Control FSM and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            sign_reg    <= 1'b0;
            exp_reg     <= 15'd0;
            man_reg     <= 64'd0;
            shift_reg   <= 6'd0;
            zero_reg    <= 1'b0;
            denorm_reg  <= 1'b0;
            i_ready_reg <= 1'b1;
            o_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_valid && i_ready_reg) begin
                        sign_reg    <= i_a[79];
                        exp_reg     <= i_a[F80_EXP_MSB:F80_EXP_LSB];
                        man_reg     <= i_a[F80_MAN_MSB:0];
                        shift_reg   <= 6'd0;
                        zero_reg    <= 1'b0;
                        denorm_reg  <= 1'b0;
                        i_ready_reg <= 1'b0;
                        case (in_cls)
                            CLS_ZERO: begin
                                exp_reg     <= 15'd0;
                                zero_reg    <= 1'b1;
                                o_valid_reg <= 1'b1;
                                state_reg   <= DONE;
                            end
                            CLS_PSEUDO: begin
                                // Same value as exp=1 with the integer bit set.
                                exp_reg     <= 15'd1;
                                o_valid_reg <= 1'b1;
                                state_reg   <= DONE;
                            end
                            CLS_DENORM: begin
                                denorm_reg  <= 1'b1;
                                o_valid_reg <= 1'b1;
                                state_reg   <= DONE;
                            end
                            CLS_INFNAN, CLS_NORMAL: begin
                                o_valid_reg <= 1'b1;
                                state_reg   <= DONE;
                            end
                            default: begin
                                state_reg <= SHIFT;
                            end
                        endcase
                    end
                end

                SHIFT: begin
                    if (man_reg[F80_MAN_MSB]) begin
                        o_valid_reg <= 1'b1;
                        state_reg   <= DONE;
                    end else if (exp_reg == 15'd1) begin
                        // Denormal scale equals the exp=1 scale: just relabel.
                        exp_reg     <= 15'd0;
                        denorm_reg  <= 1'b1;
                        o_valid_reg <= 1'b1;
                        state_reg   <= DONE;
                    end else begin
                        man_reg   <= man_next;
                        exp_reg   <= exp_next;
                        shift_reg <= shift_reg + shift_inc;
                        // Leave as soon as the integer bit lands, saving a cycle.
                        if (man_next[F80_MAN_MSB]) begin
                            o_valid_reg <= 1'b1;
                            state_reg   <= DONE;
                        end
                    end
                end

                DONE: begin
                    if (o_ready) begin
                        o_valid_reg <= 1'b0;
                        i_ready_reg <= 1'b1;
                        state_reg   <= IDLE;
                    end
                end

                default: begin
                    o_valid_reg <= 1'b0;
                    i_ready_reg <= 1'b1;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    assign i_ready  = i_ready_reg;
    assign o_valid  = o_valid_reg;
    assign o_a      = {sign_reg, exp_reg, man_reg};
    assign o_zero   = zero_reg;
    assign o_denorm = denorm_reg;
    assign o_shift  = shift_reg;

endmodule

// File: tb/tb_f80_normalize_seq.sv
// Self-checking bench for f80_normalize_seq: directed cases from the operand
// rules, randomised operands against a value-level reference, backpressure,
// mid-operation reset and back-to-back throughput.
module tb_f80_normalize_seq;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [79:0] i_a;
    logic        o_valid;
    logic        o_ready;
    logic [79:0] o_a;
    logic        o_zero;
    logic        o_denorm;
    logic [5:0]  o_shift;

    int tests = 0;
    int fails = 0;

    f80_normalize_seq #(.STEP(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_a      (i_a),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_a      (o_a),
        .o_zero   (o_zero),
        .o_denorm (o_denorm),
        .o_shift  (o_shift)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Value-level reference: normalising an unnormal means removing its
    // leading zeros, limited by how far the exponent can drop to 1; anything
    // that does not fit becomes a denormal at exponent 0.
    function automatic void ref_model(input logic [79:0] a, output logic [79:0] r,
                                      output logic z, output logic d, output logic [5:0] sh);
        logic        s;
        int          e;
        logic [63:0] m;
        int          lz;
        s  = a[79];
        e  = int'(a[78:64]);
        m  = a[63:0];
        z  = 1'b0;
        d  = 1'b0;
        sh = 6'd0;
        if (m == 64'd0 && e != 32767) begin
            z = 1'b1;
            e = 0;
        end else if (e == 32767) begin
            e = 32767;
        end else if (e == 0 && m[63]) begin
            e = 1;
        end else if (e == 0) begin
            d = 1'b1;
        end else if (!m[63]) begin
            lz = 0;
            while (!m[63 - lz]) lz++;
            if (e - 1 >= lz) begin
                m  = m << lz;
                e  = e - lz;
                sh = 6'(lz);
            end else begin
                m  = m << (e - 1);
                sh = 6'(e - 1);
                e  = 0;
                d  = 1'b1;
            end
        end
        r = {s, 15'(e), m};
    endfunction

    task automatic start(input logic [79:0] a);
        int n;
        n = 0;
        while (!i_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $error("FAIL accept_timeout observed=i_ready_low expected=i_ready_high");
        end
        i_valid = 1'b1;
        i_a     = a;
        tick();
        i_valid = 1'b0;
        i_a     = {$urandom, $urandom, $urandom};
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!o_valid && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $error("FAIL valid_timeout observed=%0d expected=<200", n);
        end
    endtask

    task automatic check_out(input string tag, input logic [79:0] ea, input logic ez,
                             input logic ed, input logic [5:0] esh);
        chk({tag, ".o_a"}, o_a, ea);
        chk({tag, ".o_zero"}, 80'(o_zero), 80'(ez));
        chk({tag, ".o_denorm"}, 80'(o_denorm), 80'(ed));
        chk({tag, ".o_shift"}, 80'(o_shift), 80'(esh));
    endtask

    task automatic release_out(input string tag);
        o_ready = 1'b1;
        tick();
        chk({tag, ".post_valid"}, 80'(o_valid), 80'd0);
        chk({tag, ".post_ready"}, 80'(i_ready), 80'd1);
    endtask

    // One full transaction; elat < 0 skips the latency comparison.
    task automatic run_op(input string tag, input logic [79:0] a, input logic [79:0] ea,
                          input logic ez, input logic ed, input logic [5:0] esh, input int elat);
        int lat;
        o_ready = 1'b1;
        start(a);
        wait_valid(lat);
        if (elat >= 0) chk({tag, ".latency"}, 80'(lat), 80'(elat));
        check_out(tag, ea, ez, ed, esh);
        $display("[TB] %s a=%h -> o_a=%h z=%0d d=%0d sh=%0d lat=%0d",
                 tag, a, o_a, o_zero, o_denorm, o_shift, lat);
        release_out(tag);
    endtask

    task automatic run_ref(input string tag, input logic [79:0] a);
        logic [79:0] ea;
        logic        ez;
        logic        ed;
        logic [5:0]  esh;
        ref_model(a, ea, ez, ed, esh);
        run_op(tag, a, ea, ez, ed, esh, -1);
    endtask

    initial begin
        logic [79:0] long_op;
        logic [79:0] ea;
        logic        ez;
        logic        ed;
        logic [5:0]  esh;
        logic [79:0] op;
        logic [63:0] man;
        logic [14:0] ex;
        int          lat;

        rst     = 1'b1;
        i_valid = 1'b0;
        i_a     = 80'd0;
        o_ready = 1'b1;
        tick();
        tick();
        chk("reset.i_ready", 80'(i_ready), 80'd1);
        chk("reset.o_valid", 80'(o_valid), 80'd0);
        check_out("reset", 80'd0, 1'b0, 1'b0, 6'd0);
        rst = 1'b0;
        tick();

        // Directed operands with hand-derived results and latencies.
        run_op("short_shift", {1'b0, 15'h4002, 64'h1000_0000_0000_0000},
               {1'b0, 15'h3FFF, 64'h8000_0000_0000_0000}, 1'b0, 1'b0, 6'd3, 3);
        run_op("long_shift", {1'b1, 15'h4000, 64'h0000_0000_0000_0001},
               {1'b1, 15'h3FC1, 64'h8000_0000_0000_0000}, 1'b0, 1'b0, 6'd63, 14);
        run_op("to_denorm", {1'b0, 15'h0003, 64'h0000_0001_0000_0000},
               {1'b0, 15'h0000, 64'h0000_0004_0000_0000}, 1'b0, 1'b1, 6'd2, 3);
        run_op("zero", {1'b1, 15'h1234, 64'h0},
               {1'b1, 15'h0000, 64'h0}, 1'b1, 1'b0, 6'd0, 0);
        run_op("nan", {1'b0, 15'h7FFF, 64'hC000_0000_0000_0000},
               {1'b0, 15'h7FFF, 64'hC000_0000_0000_0000}, 1'b0, 1'b0, 6'd0, 0);
        run_op("pseudo_denorm", {1'b1, 15'h0000, 64'h8000_0000_0000_0000},
               {1'b1, 15'h0001, 64'h8000_0000_0000_0000}, 1'b0, 1'b0, 6'd0, 0);
        run_op("denorm_in", {1'b0, 15'h0000, 64'h0000_0000_0123_4567},
               {1'b0, 15'h0000, 64'h0000_0000_0123_4567}, 1'b0, 1'b1, 6'd0, 0);
        run_op("exp1_unnormal", {1'b0, 15'h0001, 64'h4000_0000_0000_0000},
               {1'b0, 15'h0000, 64'h4000_0000_0000_0000}, 1'b0, 1'b1, 6'd0, 1);

        // Randomised operands across exponent ranges and leading-zero counts.
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 3))
                0:       ex = 15'd0;
                1:       ex = 15'($urandom_range(1, 3));
                2:       ex = 15'($urandom_range(4, 80));
                default: ex = 15'($urandom_range(81, 32767));
            endcase
            man = {$urandom, $urandom};
            man = man >> $urandom_range(0, 64);
            op  = {1'($urandom), ex, man};
            run_ref($sformatf("rand%0d", k), op);
        end

        // Backpressure: result and flags must hold while o_ready is low.
        long_op = {1'b0, 15'h4000, 64'h0000_0000_0000_0001};
        ref_model(long_op, ea, ez, ed, esh);
        o_ready = 1'b0;
        start(long_op);
        wait_valid(lat);
        for (int c = 0; c < 10; c++) begin
            chk("bp.o_valid", 80'(o_valid), 80'd1);
            chk("bp.i_ready", 80'(i_ready), 80'd0);
            check_out("bp", ea, ez, ed, esh);
            $display("[TB] backpressure cycle %0d o_a=%h i_ready=%0d", c, o_a, i_ready);
            tick();
        end
        release_out("bp");

        // Reset while shifting drops the operand immediately.
        o_ready = 1'b1;
        start(long_op);
        tick();
        tick();
        chk("rst_mid.busy", 80'(o_valid), 80'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid.o_valid", 80'(o_valid), 80'd0);
        chk("rst_mid.i_ready", 80'(i_ready), 80'd1);
        chk("rst_mid.o_a", o_a, 80'd0);
        $display("[TB] reset mid-shift o_valid=%0d i_ready=%0d", o_valid, i_ready);
        tick();

        // Back-to-back normal operands with i_valid held high: one result
        // every two cycles, unchanged, zero shift.
        o_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            op = {1'($urandom), 15'($urandom_range(1, 32766)), 1'b1, 63'({$urandom, $urandom})};
            i_a     = op;
            i_valid = 1'b1;
            tick();
            chk("b2b.o_valid", 80'(o_valid), 80'd1);
            chk("b2b.i_ready", 80'(i_ready), 80'd0);
            check_out("b2b", op, 1'b0, 1'b0, 6'd0);
            $display("[TB] b2b%0d a=%h -> o_a=%h", k, op, o_a);
            tick();
            chk("b2b.gap_valid", 80'(o_valid), 80'd0);
            chk("b2b.gap_ready", 80'(i_ready), 80'd1);
        end
        i_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/f80_normalize_seq.md
Name: f80_normalize_seq

Overview:
- Iterative pre-normaliser for 80-bit extended-precision operands, placed directly upstream of the F80-to-F32 converter.
- Converts unnormals, pseudo-denormals and unnormalised zeros into canonical form (explicit integer bit set, or a true denormal or zero), so the converter can truncate mantissa bits [63:41] safely.
- Uses a valid/ready handshake on both sides and handles one operand at a time.

Parameters:
- STEP, 8, maximum left-shift per cycle when a whole STEP-bit group of leading zeros is present (legal values: 2..16).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  input operand valid
- i_ready  out  1  block can accept an operand
- i_a  in  80  operand {sign, exp[14:0], man[63:0]}
- o_valid  out  1  result valid
- o_ready  in  1  consumer accepts result
- o_a  out  80  normalised operand
- o_zero  out  1  result is ±0
- o_denorm  out  1  result is a denormal (exp==0, man[63]==0, man!=0)
- o_shift  out  6  total left-shift applied (0..63)

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset state:
  - state=IDLE, i_ready=1, o_valid=0.
  - o_a=0, o_zero=0, o_denorm=0, o_shift=0.
  - rst mid-operation discards the operand in flight; there is no partial output.
- States: IDLE, SHIFT, DONE.
- IDLE, with i_valid&i_ready: latch the operand, clear the shift counter, drop i_ready, then classify in this order:
  - man==0 → DONE with exp=0, sign kept, o_zero=1 (exp is forced to 0 for any exponent except 0x7FFF).
  - exp==0x7FFF → DONE, passed through unchanged (inf/NaN).
  - exp==0 and man[63]==1 (pseudo-denormal) → DONE with exp=1, man unchanged.
  - exp==0 and man[63]==0 → DONE unchanged, o_denorm=1.
  - man[63]==1 → DONE unchanged (already normal, o_shift=0).
  - otherwise → SHIFT.
- SHIFT, one action per cycle:
  - man[63]==1 → DONE.
  - else if exp==1 → exp=0, man unchanged, o_denorm=1, then DONE (denormal scale equals exp-1 scale).
  - else if man[63:64-STEP]==0 and exp>STEP → man<<=STEP, exp-=STEP, shift+=STEP.
  - else → man<<=1, exp-=1, shift+=1.
  - Worst case with STEP=8 is 14 cycles in SHIFT; exp never goes below 0 and shift never exceeds 63.
- DONE:
  - o_valid=1; o_a, o_zero, o_denorm and o_shift are held stable until o_valid&o_ready.
  - Then: o_valid=0, i_ready=1, → IDLE.
  - The handshake and the IDLE accept are not overlapped, so minimum occupancy is 2 cycles: accept, then DONE.
- i_a is sampled only on the accept edge; changes to it at other times are ignored.
- o_ready held low: DONE persists indefinitely and i_ready stays 0.
- The sign bit passes through untouched in every path.

Decomposition:
- Shared package fp80_pkg holds:
  - the field-extraction constants F80_EXP_MSB=78, F80_EXP_LSB=64, F80_MAN_MSB=63;
  - F80_EXP_MAX=15'h7FFF and F80_BIAS=15'h3FFF;
  - the state enum typedef norm_state_t {IDLE,SHIFT,DONE}.
- Classification (zero/inf/pseudo-denormal/denormal/normal) is a natural sub-module, f80_classify: purely combinational and reusable by the converter.

Test Plan:
- exp=0x4002, man=0x1000_0000_0000_0000 → 3 SHIFT cycles; o_a exp=0x3FFF, man=0x8000_0000_0000_0000, o_shift=3, o_denorm=0.
- exp=0x4000, man=0x0000_0000_0000_0001 → 7 STEP shifts + 7 single shifts (14 cycles); exp=0x3FC1, man=0x8000_0000_0000_0000, o_shift=63.
- exp=0x0003, man=0x0000_0001_0000_0000 → exp=0, man=0x0000_0004_0000_0000, o_denorm=1, o_shift=2.
- Special operands, in sequence:
  - exp=0x1234, man=0 → o_zero=1, exp=0.
  - exp=0x7FFF, man=0xC000_0000_0000_0000 → passed through unchanged.
  - exp=0, man=0x8000_0000_0000_0000 → exp=1.
- Backpressure and reset, using a long-shift operand: o_ready=0 for 10 cycles in DONE gives stable outputs and i_ready=0; asserting rst during SHIFT gives o_valid=0 and i_ready=1 next cycle.
- Back-to-back normal operands with o_ready=1 → throughput of exactly one result per 2 cycles, outputs equal to inputs, o_shift=0.
